// File: rtl/rc5_key_expander_param_pkg.sv
// Shared FSM encodings, magic constants and size helpers for the RC5-W/R/B key expander.
package rc5_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_L = 3'd1;
    localparam logic [2:0] ST_INIT_S = 3'd2;
    localparam logic [2:0] ST_MIX    = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    function automatic logic [63:0] rc5_pw(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_B7E1;
            64:      return 64'hB7E1_5162_8AED_2A6B;
            default: return 64'h0000_0000_B7E1_5163;
        endcase
    endfunction

    function automatic logic [63:0] rc5_qw(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_9E37;
            64:      return 64'h9E37_79B9_7F4A_7C15;
            default: return 64'h0000_0000_9E37_79B9;
        endcase
    endfunction

    function automatic int rc5_u(input int w);
        return w / 8;
    endfunction

    function automatic int rc5_t(input int r);
        return 2 * (r + 1);
    endfunction

    function automatic int rc5_c(input int b, input int w);
        return (b + rc5_u(w) - 1) / rc5_u(w);
    endfunction

    function automatic int rc5_n(input int w, input int r, input int b);
        int t;
        int c;
        t = rc5_t(r);
        c = rc5_c(b, w);
        return 3 * ((t > c) ? t : c);
    endfunction

    // Index width for an n-entry table; never narrower than one bit.
    function automatic int rc5_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rc5_key_expander_param_if.sv
// Bus bundle for rc5_key_expander_param: key byte write port, start/done handshake and S read port.
interface rc5_key_expander_param_if #(
    parameter int W = 32,
    parameter int R = 12,
    parameter int B = 16
);
    import rc5_pkg::*;

    localparam int KAW = rc5_idx_w(B);
    localparam int TAW = rc5_idx_w(rc5_t(R));

    logic           key_we;
    logic [KAW-1:0] key_addr;
    logic [7:0]     key_byte;
    logic           start;
    logic           busy;
    logic           done;
    logic           s_valid;
    logic [TAW-1:0] s_rd_addr;
    logic [W-1:0]   s_rd_data;

    modport master (
        output key_we, key_addr, key_byte, start, s_rd_addr,
        input  busy, done, s_valid, s_rd_data
    );

    modport slave (
        input  key_we, key_addr, key_byte, start, s_rd_addr,
        output busy, done, s_valid, s_rd_data
    );

endinterface

// File: rtl/rc5_key_expander_param_rotl.sv
// Combinational left rotate of a W-bit word by a log2(W)-bit amount.
module rc5_rotl #(
    parameter int W = 32
) (
    input  logic [W-1:0]         din,
    input  logic [$clog2(W)-1:0] amt,
    output logic [W-1:0]         dout
);

    logic [2*W-1:0] dbl;

    // Bits shifted out of the top half wrap in from the duplicated copy.
    assign dbl  = {din, din} << amt;
    assign dout = dbl[2*W-1:W];

endmodule

// File: rtl/rc5_key_expander_param.sv
// Parametrised RC5-W/R/B key schedule with key byte port, start/done handshake and S read port.
// Define KEY_ZEROIZE_EN to wipe K[] and L[] in the cycle S becomes valid.
module rc5_key_expander_param
    import rc5_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 12,
    parameter int B = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    rc5_key_expander_param_if.slave  bus
);

    localparam int U   = rc5_u(W);
    localparam int T   = rc5_t(R);
    localparam int C   = rc5_c(B, W);
    localparam int N   = rc5_n(W, R, B);
    localparam int KAW = rc5_idx_w(B);
    localparam int KD  = 2 ** KAW;
    localparam int TAW = rc5_idx_w(T);
    localparam int CAW = rc5_idx_w(C);
    localparam int NW  = $clog2(N + 1);
    localparam int RW  = $clog2(W);
    localparam int USH = $clog2(U);

    localparam logic [63:0]   PW64  = rc5_pw(W);
    localparam logic [63:0]   QW64  = rc5_qw(W);
    localparam logic [W-1:0]  PW    = PW64[W-1:0];
    localparam logic [W-1:0]  QW    = QW64[W-1:0];
    localparam logic [RW-1:0] ROT_A = RW'(3);

    logic [2:0]            state;
    logic [KD-1:0][7:0]    k_mem;
    logic [C-1:0][W-1:0]   l_mem;
    logic [T-1:0][W-1:0]   s_mem;
    logic [KAW-1:0]        bi;
    logic [TAW-1:0]        si;
    logic [CAW-1:0]        lj;
    logic [NW-1:0]         cnt;
    logic [W-1:0]          a_reg;
    logic [W-1:0]          b_reg;
    logic                  busy_r;
    logic                  done_r;
    logic                  valid_r;
    logic [W-1:0]          rd_data_p1;

    logic [CAW-1:0]        lidx;
    logic [W-1:0]          a_sum;
    logic [W-1:0]          a_new;
    logic [W-1:0]          b_sum;
    logic [W-1:0]          b_new;
    logic [RW-1:0]         b_amt;

    assign lidx  = CAW'(bi >> USH);
    assign a_sum = s_mem[si] + a_reg + b_reg;
    assign b_sum = l_mem[lj] + a_new + b_reg;
    // Only the low log2(W) bits of A'+B_ feed the rotate, and they depend only on the low operand bits.
    assign b_amt = a_new[RW-1:0] + b_reg[RW-1:0];

    rc5_rotl #(.W(W)) u_rotl_a (.din(a_sum), .amt(ROT_A), .dout(a_new));
    rc5_rotl #(.W(W)) u_rotl_b (.din(b_sum), .amt(b_amt), .dout(b_new));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
            rd_data_p1 <= '0;
            k_mem      <= '0;
            l_mem      <= '0;
            s_mem      <= '0;
            bi         <= '0;
            si         <= '0;
            lj         <= '0;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
        end else begin
            done_r <= 1'b0;

            // Read port stage: one-cycle latency, zero unless a complete table is flagged valid.
            if (valid_r && (32'(bus.s_rd_addr) < T))
                rd_data_p1 <= s_mem[bus.s_rd_addr];
            else
                rd_data_p1 <= '0;

            case (state)
                ST_IDLE: begin
                    if (bus.key_we)
                        k_mem[bus.key_addr] <= bus.key_byte;
                    if (bus.start) begin
                        l_mem   <= '0;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b0;
                        bi      <= KAW'(B - 1);
                        si      <= '0;
                        a_reg   <= PW;
                        state   <= ST_LOAD_L;
                    end
                end
                ST_LOAD_L: begin
                    l_mem[lidx] <= (l_mem[lidx] << 8) + {{(W-8){1'b0}}, k_mem[bi]};
                    bi          <= bi - KAW'(1);
                    if (bi == '0)
                        state <= ST_INIT_S;
                end
                ST_INIT_S: begin
                    // a_reg carries the running Pw + k*Qw so S is never read back here.
                    s_mem[si] <= a_reg;
                    a_reg     <= a_reg + QW;
                    if (32'(si) == T - 1) begin
                        si    <= '0;
                        lj    <= '0;
                        cnt   <= '0;
                        a_reg <= '0;
                        b_reg <= '0;
                        state <= ST_MIX;
                    end else begin
                        si <= si + TAW'(1);
                    end
                end
                ST_MIX: begin
                    s_mem[si] <= a_new;
                    l_mem[lj] <= b_new;
                    a_reg     <= a_new;
                    b_reg     <= b_new;
                    si        <= (32'(si) == T - 1) ? '0 : si + TAW'(1);
                    lj        <= (32'(lj) == C - 1) ? '0 : lj + CAW'(1);
                    cnt       <= cnt + NW'(1);
                    if (cnt == NW'(N - 1))
                        state <= ST_FIN;
                end
                ST_FIN: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    valid_r <= 1'b1;
                    state   <= ST_IDLE;
`ifdef KEY_ZEROIZE_EN
                    k_mem   <= '0;
                    l_mem   <= '0;
`else
                    k_mem   <= k_mem;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.s_valid   = valid_r;
    assign bus.s_rd_data = rd_data_p1;

endmodule
